// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, frame length and
// default bit timing, used by both the transmit and receive sides.
package uart_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic c_HIGH = 1'b1;
    localparam logic c_LOW  = 1'b0;

    localparam int c_BIT_LENGTH             = 8;
    localparam int c_DEFAULT_CYCLES_PER_BIT = 217;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO; pointers carry one extra wrap bit so
// full and empty are told apart by the MSB.
module uart_rx_fifo #(
    parameter int c_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int c_AW = $clog2(c_DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [c_DEPTH];
    logic [c_AW:0] wr_q;
    logic [c_AW:0] rd_q;
    logic        wr_en_s;
    logic        rd_en_s;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[c_AW] != rd_q[c_AW]) && (wr_q[c_AW-1:0] == rd_q[c_AW-1:0]);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en_s = push_i && (!full_o || pop_i);
    assign rd_en_s = pop_i && !empty_o;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_q[c_AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en_s) begin
                wr_q <= wr_q + c_PTR_ONE;
            end
            if (rd_en_s) begin
                rd_q <= rd_q + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_q[c_AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 3-sample majority voting, framing-error/break
// handling and a small FWFT output FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT,
    parameter int c_FIFO_DEPTH     = 4
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_SERIAL_DATA,
    input  logic       i_RX_READY,
    output logic [7:0] o_DATA_RX,
    output logic       o_RX_DATA_VALID,
    output logic       o_FRAMING_ERROR,
    output logic       o_OVERRUN,
    output logic       o_RX_BUSY
);

    localparam logic [15:0] c_LAST = 16'(c_CYCLES_PER_BIT - 1);
    localparam logic [15:0] c_S0   = 16'(c_CYCLES_PER_BIT / 2 - 1);
    localparam logic [15:0] c_MID  = 16'(c_CYCLES_PER_BIT / 2);
    localparam logic [15:0] c_DEC  = 16'(c_CYCLES_PER_BIT / 2 + 1);
    localparam logic [2:0]  c_LAST_BIT = 3'(c_BIT_LENGTH - 1);

    logic [1:0]  sync_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  smp_q, smp_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        line_s, decide_s, vote_s, push_s, pop_s;
    logic        full_s, empty_s;
    logic [7:0]  head_s;

    assign line_s   = sync_q[1];
    assign decide_s = (cnt_q == c_DEC);
    assign vote_s   = majority3(smp_q[0], smp_q[1], line_s);
    assign pop_s    = !empty_s && i_RX_READY;

    // Bit timing, sampling and frame FSM.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        smp_d     = smp_q;
        push_s    = 1'b0;
        ferr_d    = 1'b0;
        if (state_q == S_IDLE || state_q == S_BREAK) begin
            cnt_d = 16'd0;
        end else if (cnt_q == c_LAST) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        if (cnt_q == c_S0) begin
            smp_d[0] = line_s;
        end else if (cnt_q == c_MID) begin
            smp_d[1] = line_s;
        end else begin
            smp_d = smp_q;
        end
        case (state_q)
            S_IDLE: begin
                // The edge cycle itself counts as c = 0.
                if (line_s == c_LOW) begin
                    state_d = S_START;
                    cnt_d   = 16'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (decide_s) begin
                    if (vote_s == c_HIGH) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (decide_s) begin
                    shift_d = {vote_s, shift_q[7:1]};
                    if (bit_idx_q == c_LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (decide_s) begin
                    if (vote_s == c_HIGH) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                if (line_s == c_HIGH) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ovr_d = push_s && full_s && !pop_s;
    end

    // Synchronizer and receiver state registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            smp_q     <= 2'b00;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_SERIAL_DATA};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    uart_rx_fifo #(
        .c_DEPTH(c_FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (i_CLK),
        .reset_i    (i_RESET),
        .push_i     (push_s),
        .push_data_i(shift_d),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .full_o     (full_s),
        .empty_o    (empty_s)
    );

    assign o_DATA_RX       = head_s;
    assign o_RX_DATA_VALID = !empty_s;
    assign o_FRAMING_ERROR = ferr_q;
    assign o_OVERRUN       = ovr_q;
    assign o_RX_BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: frame-level queue model checked every cycle,
// plus literal expectations on received byte sequences and pulse counts.
module tb_uart_rx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Drive-to-effect: 2 sync cycles, stop decision at t0+M+1+9*CPB, seen one cycle later.
    localparam int LAT   = 2 + (CPB / 2 + 1) + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr, busy;

    int vectors = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 1'b0;

    logic [7:0] mq[$];
    logic [7:0] push_at[int];
    bit         ferr_at[int];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr = 1'b0;
    bit         full_b, pop_b;
    logic [7:0] got[$];
    logic [7:0] want[$];
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic [10:0] act_v, exp_v;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .c_CYCLES_PER_BIT(CPB),
        .c_FIFO_DEPTH(DEPTH)
    ) dut (
        .i_CLK(clk),
        .i_RESET(rst),
        .i_SERIAL_DATA(serial),
        .i_RX_READY(rx_ready),
        .o_DATA_RX(data),
        .o_RX_DATA_VALID(valid),
        .o_FRAMING_ERROR(ferr),
        .o_OVERRUN(ovr),
        .o_RX_BUSY(busy)
    );

    // Model: queue of bytes the receiver must hold, updated at each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
        if (rst) begin
            mq.delete();
            push_at.delete();
            ferr_at.delete();
        end else begin
            full_b = (mq.size() == DEPTH);
            pop_b = (mq.size() != 0) && rx_ready;
            if (pop_b) void'(mq.pop_front());
            if (push_at.exists(cyc)) begin
                if (full_b && !pop_b) exp_ovr = 1'b1;
                else mq.push_back(push_at[cyc]);
                push_at.delete(cyc);
            end
            if (ferr_at.exists(cyc)) begin
                exp_ferr = 1'b1;
                ferr_at.delete(cyc);
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (checking) begin
            exp_v = {mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00, exp_ferr, exp_ovr};
            act_v = {valid, valid ? data : 8'h00, ferr, ovr};
            vectors++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL cycle %0d {valid,data,ferr,ovr}: got %h, expected %h", cyc, act_v, exp_v);
            end
            if (valid && rx_ready) got.push_back(data);
            if (ferr) ferr_cnt++;
            if (ovr) ovr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_got(input string name);
        check({name, " count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (i < got.size()) check(name, 32'(got[i]), 32'(want[i]));
        end
    endtask

    task automatic sync_up();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int k);
        serial = v;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low, input bit glitch);
        int n;
        n = cyc;
        if (stop_low > 0) ferr_at[n + LAT] = 1'b1;
        else push_at[n + LAT] = b;
        hold(1'b0, CPB);
        for (int k = 0; k < 8; k++) begin
            if (glitch) begin
                hold(b[k], CPB / 2);
                hold(~b[k], 1);
                hold(b[k], CPB / 2 - 1);
            end else begin
                hold(b[k], CPB);
            end
        end
        if (stop_low > 0) hold(1'b0, stop_low * CPB);
        else hold(1'b1, CPB);
    endtask

    int ovr0, ferr0;
    logic [7:0] pb;

    initial begin
        @(posedge clk);
        #1 checking = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset data", data, 8'h00);
        check("reset valid", valid, 1'b0);
        check("reset ferr", ferr, 1'b0);
        check("reset ovr", ovr, 1'b0);
        check("reset busy", busy, 1'b0);
        sync_up();
        hold(1'b1, 4);

        // Single frame, consumer always ready.
        rx_ready = 1'b1;
        got.delete();
        send_frame(8'h27, 0, 1'b0);
        hold(1'b1, 4);
        want = '{8'h27};
        check_got("t1 bytes");
        check("t1 ferr pulses", ferr_cnt, 0);
        check("t1 ovr pulses", ovr_cnt, 0);

        // Back-to-back frames buffered, then drained.
        rx_ready = 1'b0;
        got.delete();
        send_frame(8'h55, 0, 1'b0);
        send_frame(8'hA5, 0, 1'b0);
        send_frame(8'h00, 0, 1'b0);
        hold(1'b1, 4);
        check("t2 valid before drain", valid, 1'b1);
        rx_ready = 1'b1;
        hold(1'b1, 8);
        rx_ready = 1'b0;
        want = '{8'h55, 8'hA5, 8'h00};
        check_got("t2 bytes");
        check("t2 valid after drain", valid, 1'b0);

        // Overrun on fifth frame, then push-while-pop when full.
        got.delete();
        ovr0 = ovr_cnt;
        send_frame(8'h10, 0, 1'b0);
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h12, 0, 1'b0);
        send_frame(8'h13, 0, 1'b0);
        send_frame(8'h14, 0, 1'b0);
        hold(1'b1, 4);
        check("t3 overrun pulses", ovr_cnt - ovr0, 1);
        check("t3 head when full", data, 8'h10);
        fork
            send_frame(8'h15, 0, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        hold(1'b1, 4);
        check("t3 no overrun on pop+push", ovr_cnt - ovr0, 1);
        rx_ready = 1'b1;
        hold(1'b1, 8);
        rx_ready = 1'b0;
        want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h15};
        check_got("t3 bytes");

        // Mid-bit glitches are voted out; short low pulse is a false start.
        got.delete();
        rx_ready = 1'b1;
        send_frame(8'hF0, 0, 1'b1);
        hold(1'b1, 4);
        want = '{8'hF0};
        check_got("t4 glitch bytes");
        got.delete();
        hold(1'b0, 3);
        check("t4 busy in start", busy, 1'b1);
        hold(1'b1, 40);
        want.delete();
        check_got("t4 false start");
        check("t4 busy after false start", busy, 1'b0);

        // Stop bit held low: one framing error, then a clean frame.
        got.delete();
        ferr0 = ferr_cnt;
        send_frame(8'h3C, 20, 1'b0);
        check("t5 busy in break", busy, 1'b1);
        check("t5 ferr pulses", ferr_cnt - ferr0, 1);
        hold(1'b1, 32);
        check("t5 ferr pulses after release", ferr_cnt - ferr0, 1);
        check("t5 nothing queued", valid, 1'b0);
        send_frame(8'h81, 0, 1'b0);
        hold(1'b1, 4);
        want = '{8'h81};
        check_got("t5 bytes");

        // Reset mid-frame with a byte already queued.
        rx_ready = 1'b0;
        got.delete();
        send_frame(8'h99, 0, 1'b0);
        hold(1'b1, 4);
        check("t6 byte queued", valid, 1'b1);
        pb = 8'h27;
        hold(1'b0, CPB);
        for (int k = 0; k < 4; k++) hold(pb[k], CPB);
        hold(pb[4], CPB / 2);
        check("t6 busy mid frame", busy, 1'b1);
        rst = 1'b1;
        serial = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6 reset data", data, 8'h00);
        check("t6 reset valid", valid, 1'b0);
        check("t6 reset busy", busy, 1'b0);
        check("t6 reset ferr", ferr, 1'b0);
        check("t6 reset ovr", ovr, 1'b0);
        sync_up();
        rst = 1'b0;
        hold(1'b1, 20);
        rx_ready = 1'b1;
        send_frame(8'h27, 0, 1'b0);
        hold(1'b1, 4);
        want = '{8'h27};
        check_got("t6 bytes after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
